// File: rtl/scan_chain_ctl.sv
// scan_chain_ctl: scan-test initiator for one mux-D scan chain.
// Each test shifts a pattern into the chain, pulses capture with SCE low,
// then unloads the captured response from the chain tail into RESPONSE.
// Handshake: START is a level request honoured only on a launch edge (IDLE, or
// FIN for back-to-back tests); DONE is a one-cycle pulse marking RESPONSE valid;
// ABORT returns to IDLE on the next edge without DONE and without touching RESPONSE.
module scan_chain_ctl #(
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESETB,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PATTERN,
    input  logic                 SO,
    output logic                 SCE,
    output logic                 SCD,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESPONSE
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t                state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [CHAIN_LEN-1:0]  shreg_q,   shreg_d;
    logic [CHAIN_LEN-1:0]  resp_sh_q, resp_sh_d;
    logic [CHAIN_LEN-1:0]  resp_q,    resp_d;
    logic                  sce_q,     sce_d;
    logic                  scd_q,     scd_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  launch;

    // Next-state and registered-output values for every state, abort applied last.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        resp_sh_d = resp_sh_q;
        resp_d    = resp_q;
        sce_d     = 1'b0;
        scd_d     = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        launch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                launch = START;
            end
            S_SHIFT: begin
                sce_d   = 1'b1;
                scd_d   = shreg_q[CHAIN_LEN-2];
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                    sce_d   = 1'b0;
                    scd_d   = 1'b0;
                end
            end
            S_CAPTURE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CAP_LAST) begin
                    state_d = S_UNLOAD;
                    cnt_d   = '0;
                    sce_d   = 1'b1;
                end
            end
            S_UNLOAD: begin
                sce_d     = 1'b1;
                resp_sh_d = {resp_sh_q[CHAIN_LEN-2:0], SO};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                    sce_d   = 1'b0;
                    done_d  = 1'b1;
                    resp_d  = {resp_sh_q[CHAIN_LEN-2:0], SO};
                end
            end
            S_FIN: begin
                // The FIN exit edge doubles as the launch edge so a held START
                // runs tests back-to-back without an idle gap.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                launch  = START;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (launch) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            shreg_d = PATTERN;
            sce_d   = 1'b1;
            scd_d   = PATTERN[CHAIN_LEN-1];
            busy_d  = 1'b1;
        end

        if (ABORT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = shreg_q;
            sce_d   = 1'b0;
            scd_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            resp_d  = resp_q;
        end
    end

    // State, counter, data registers and registered outputs.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            resp_sh_q <= '0;
            resp_q    <= '0;
            sce_q     <= 1'b0;
            scd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            resp_sh_q <= resp_sh_d;
            resp_q    <= resp_d;
            sce_q     <= sce_d;
            scd_q     <= scd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SCE      = sce_q;
    assign SCD      = scd_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RESPONSE = resp_q;

endmodule
